// File: rtl/intn_to_fp_vec.sv
// intn_to_fp_vec: multi-lane signed-integer to floating-point converter.
// Two-register pipeline with valid/ready flow control. Stage 1 captures
// sign, magnitude, leading-zero count and zero flag per lane. Stage 2
// normalises, rounds to nearest-even, applies the per-beat scale, saturates
// to Inf, flushes underflow to signed zero and packs {sign, exp, man}.
module intn_to_fp_vec #(
    parameter int INT_WIDTH = 8,
    parameter int NUM_LANES = 4,
    parameter int EXP_WIDTH = 5,
    parameter int MAN_WIDTH = 10
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         in_valid_i,
    output logic                                         in_ready_o,
    input  logic [NUM_LANES*INT_WIDTH-1:0]               in_data_i,
    input  logic [5:0]                                   in_scale_i,
    output logic                                         out_valid_o,
    input  logic                                         out_ready_i,
    output logic [NUM_LANES*(1+EXP_WIDTH+MAN_WIDTH)-1:0] out_data_o
);

    localparam int FP_W   = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam int LZ_W   = $clog2(INT_WIDTH + 1);
    // Fraction field: everything below the leading one, padded so that the
    // mantissa, guard bit and at least one sticky bit always exist.
    localparam int FRAC_W = INT_WIDTH + MAN_WIDTH + 1;
    // Exponent arithmetic width: wide enough for bias + largest integer
    // exponent + full scale range without wrapping.
    localparam int XW     = EXP_WIDTH + 8;
    localparam int BIAS   = (1 << (EXP_WIDTH - 1)) - 1;

    localparam logic signed [XW-1:0] EXP_BASE = XW'(INT_WIDTH - 1 + BIAS);
    localparam logic signed [XW-1:0] EXP_SAT  = XW'((1 << EXP_WIDTH) - 1);

    // Leading-zero count over the magnitude; an all-zero value returns
    // INT_WIDTH, but that case is overridden by the zero flag downstream.
    function automatic logic [LZ_W-1:0] count_lz(input logic [INT_WIDTH-1:0] v);
        logic [LZ_W-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = INT_WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + LZ_W'(1);
                end
            end
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s1_free;
    logic s2_free;
    logic in_fire;
    logic s1_advance;

    assign s2_free     = !s2_valid || out_ready_i;
    assign s1_free     = !s1_valid || s2_free;
    assign in_ready_o  = s1_free;
    assign in_fire     = in_valid_i && s1_free;
    assign s1_advance  = s1_valid && s2_free;
    assign out_valid_o = s2_valid;

    // Valid bits: each stage refills whenever it is free, otherwise holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_free) begin
                s1_valid <= in_valid_i;
            end
            if (s2_free) begin
                s2_valid <= s1_valid;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: per-lane capture
    // ------------------------------------------------------------------
    logic [NUM_LANES-1:0]                 c1_sign;
    logic [NUM_LANES-1:0]                 c1_zero;
    logic [NUM_LANES-1:0][INT_WIDTH-1:0]  c1_mag;
    logic [NUM_LANES-1:0][LZ_W-1:0]       c1_lzc;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_cap
        logic [INT_WIDTH-1:0] raw;

        assign raw = in_data_i[k*INT_WIDTH +: INT_WIDTH];

        if (INT_WIDTH == 1) begin : g_bin
            // Binary mode: bit 1 is +1.0, bit 0 is -1.0; never zero.
            assign c1_sign[k] = ~raw[0];
            assign c1_mag[k]  = INT_WIDTH'(1);
            assign c1_zero[k] = 1'b0;
        end else begin : g_int
            // One extra bit so negating the most-negative value is exact.
            logic [INT_WIDTH:0] ext;
            logic [INT_WIDTH:0] abs_w;

            assign ext        = {raw[INT_WIDTH-1], raw};
            assign abs_w      = raw[INT_WIDTH-1] ? (~ext + 1'b1) : ext;
            assign c1_sign[k] = raw[INT_WIDTH-1];
            assign c1_mag[k]  = abs_w[INT_WIDTH-1:0];
            assign c1_zero[k] = (abs_w == '0);
        end

        assign c1_lzc[k] = count_lz(c1_mag[k]);
    end

    logic [NUM_LANES-1:0]                 s1_sign;
    logic [NUM_LANES-1:0]                 s1_zero;
    logic [NUM_LANES-1:0][INT_WIDTH-1:0]  s1_mag;
    logic [NUM_LANES-1:0][LZ_W-1:0]       s1_lzc;
    logic [5:0]                           s1_scale;

    // Stage 1 data registers load only when a beat is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_sign  <= '0;
            s1_zero  <= '0;
            s1_mag   <= '0;
            s1_lzc   <= '0;
            s1_scale <= '0;
        end else if (in_fire) begin
            s1_sign  <= c1_sign;
            s1_zero  <= c1_zero;
            s1_mag   <= c1_mag;
            s1_lzc   <= c1_lzc;
            s1_scale <= in_scale_i;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: normalise, round, scale, pack
    // ------------------------------------------------------------------
    logic signed [XW-1:0]          scale_x;
    logic [NUM_LANES-1:0][FP_W-1:0] c2_lane;

    assign scale_x = {{(XW - 6){s1_scale[5]}}, s1_scale};

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_pack
        logic [INT_WIDTH-1:0]  norm;
        logic [FRAC_W-1:0]     frac;
        logic [MAN_WIDTH-1:0]  mant;
        logic                  guard;
        logic                  sticky;
        logic                  round_up;
        logic [MAN_WIDTH:0]    mant_r;
        logic signed [XW-1:0]  exp_b;
        logic [FP_W-1:0]       lane_fp;

        // Leading one moves to the MSB; the cast drops that hidden bit.
        assign norm     = s1_mag[k] << s1_lzc[k];
        assign frac     = FRAC_W'({norm, {(MAN_WIDTH + 2){1'b0}}});
        assign mant     = frac[FRAC_W-1 -: MAN_WIDTH];
        assign guard    = frac[INT_WIDTH];
        assign sticky   = |frac[INT_WIDTH-1:0];
        assign round_up = guard & (sticky | mant[0]);

        // On mantissa carry-out the low bits are already zero, so only the
        // exponent needs the extra increment.
        assign mant_r   = {1'b0, mant} + (MAN_WIDTH + 1)'(round_up);
        assign exp_b    = EXP_BASE - XW'(s1_lzc[k]) + scale_x + XW'(mant_r[MAN_WIDTH]);

        // Zero input wins over scale; then overflow to Inf, then flush.
        always_comb begin
            lane_fp = {s1_sign[k], exp_b[EXP_WIDTH-1:0], mant_r[MAN_WIDTH-1:0]};
            if (s1_zero[k]) begin
                lane_fp = '0;
            end else if (exp_b >= EXP_SAT) begin
                lane_fp = {s1_sign[k], {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
            end else if (exp_b <= 0) begin
                lane_fp = {s1_sign[k], {(FP_W - 1){1'b0}}};
            end
        end

        assign c2_lane[k] = lane_fp;
    end

    // Output register loads only when stage 1 advances into stage 2.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_data_o <= '0;
        end else if (s1_advance) begin
            out_data_o <= c2_lane;
        end
    end

endmodule

// File: tb/tb_intn_to_fp_vec.sv
// Testbench for intn_to_fp_vec: three configurations (INT4/FP16,
// INT16/FP16, INT1/BF16) driven by scenario tasks with queue scoreboards.
module tb_intn_to_fp_vec;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // INT4 / FP16, 4 lanes
    logic        v4, r4, ov4, ordy4;
    logic [15:0] d4;
    logic [5:0]  s4;
    logic [63:0] o4;
    // INT16 / FP16, 4 lanes
    logic        v16, r16, ov16, ordy16;
    logic [63:0] d16;
    logic [5:0]  s16;
    logic [63:0] o16;
    // INT1 / BF16, 2 lanes
    logic        v1, r1, ov1, ordy1;
    logic [1:0]  d1;
    logic [5:0]  s1;
    logic [31:0] o1;

    logic [63:0] q4[$];
    logic [63:0] q16[$];
    logic [31:0] q1[$];

    intn_to_fp_vec #(.INT_WIDTH(4), .NUM_LANES(4), .EXP_WIDTH(5), .MAN_WIDTH(10)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v4), .in_ready_o(r4), .in_data_i(d4),
        .in_scale_i(s4), .out_valid_o(ov4), .out_ready_i(ordy4), .out_data_o(o4));

    intn_to_fp_vec #(.INT_WIDTH(16), .NUM_LANES(4), .EXP_WIDTH(5), .MAN_WIDTH(10)) u_dut16 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v16), .in_ready_o(r16), .in_data_i(d16),
        .in_scale_i(s16), .out_valid_o(ov16), .out_ready_i(ordy16), .out_data_o(o16));

    intn_to_fp_vec #(.INT_WIDTH(1), .NUM_LANES(2), .EXP_WIDTH(8), .MAN_WIDTH(7)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v1), .in_ready_o(r1), .in_data_i(d1),
        .in_scale_i(s1), .out_valid_o(ov1), .out_ready_i(ordy1), .out_data_o(o1));

    // Reference conversion of one integer lane (magnitude-based, explicit RNE).
    function automatic logic [15:0] fp_model(input int v, input int iw, input int sc,
                                             input int ew, input int mw);
        int sgn, m, e_unb, q, sh, rem, half, e_b, emax;
        if (iw == 1) begin
            sgn = (v == 0) ? 1 : 0;
            m   = 1;
        end else begin
            if (v == 0) return 16'h0000;
            sgn = (v < 0) ? 1 : 0;
            m   = (v < 0) ? -v : v;
        end
        e_unb = 0;
        while ((m >> (e_unb + 1)) != 0) e_unb++;
        if (e_unb <= mw) begin
            q = m << (mw - e_unb);
        end else begin
            sh   = e_unb - mw;
            q    = m >> sh;
            rem  = m & ((1 << sh) - 1);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
            if (q == (1 << (mw + 1))) begin
                q = q >> 1;
                e_unb++;
            end
        end
        e_b  = e_unb + sc + (1 << (ew - 1)) - 1;
        emax = (1 << ew) - 1;
        if (e_b >= emax) return 16'((sgn << (ew + mw)) | (emax << mw));
        if (e_b <= 0) return 16'(sgn << (ew + mw));
        return 16'((sgn << (ew + mw)) | (e_b << mw) | (q - (1 << mw)));
    endfunction

    function automatic logic [63:0] exp16(input logic [63:0] d, input logic [5:0] sc);
        logic [63:0] r;
        logic [15:0] lane;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            lane = d[16*k +: 16];
            r[16*k +: 16] = fp_model(int'($signed(lane)), 16, int'($signed(sc)), 5, 10);
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ov4, r4, o4} !== {1'b0, 1'b1, 64'h0}) begin
            failures++;
            $display("FAIL reset_dut4 valid=%b ready=%b data=%h required 0/1/0", ov4, r4, o4);
        end
        checks++;
        if ({ov16, r16, o16} !== {1'b0, 1'b1, 64'h0}) begin
            failures++;
            $display("FAIL reset_dut16 valid=%b ready=%b data=%h required 0/1/0", ov16, r16, o16);
        end
        checks++;
        if ({ov1, r1, o1} !== {1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL reset_dut1 valid=%b ready=%b data=%h required 0/1/0", ov1, r1, o1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_int4_basic();
        logic [63:0] expv;
        logic [5:0]  scl [2];
        logic [63:0] expc [2];
        scl  = '{6'd0, 6'h3D};
        expc = '{64'h4700_0000_BC00_C800, 64'h3B00_0000_B000_BC00};
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            ordy4 = 1'b1;
            v4    = 1'b1;
            d4    = 16'h70F8;
            s4    = scl[b];
            #1;
            checks++;
            if (r4 !== 1'b1) begin
                failures++;
                $display("FAIL int4_ready beat=%0d got=%b required=1", b, r4);
            end
            q4.push_back(expc[b]);
            @(posedge clk);
            #1;
            v4 = 1'b0;
            checks++;
            if (ov4 !== 1'b0) begin
                failures++;
                $display("FAIL int4_latency_early beat=%0d valid=%b required=0", b, ov4);
            end
            @(posedge clk);
            #1;
            checks++;
            if (ov4 !== 1'b1) begin
                failures++;
                $display("FAIL int4_latency beat=%0d valid=%b required=1", b, ov4);
            end
            expv = q4.pop_front();
            checks++;
            if (o4 !== expv) begin
                failures++;
                $display("FAIL int4_data beat=%0d got=%h required=%h", b, o4, expv);
            end
        end
    endtask

    task automatic test_rne();
        logic [63:0] stim [2];
        logic [63:0] expc [2];
        logic [63:0] expv;
        int idx;
        stim = '{64'h8000_7FFF_0803_0801, 64'hF7FD_1003_0807_0805};
        expc = '{64'hF800_7800_6802_6800, 64'hE802_6C01_6804_6802};
        idx  = 0;
        ordy16 = 1'b1;
        for (int c = 0; c < 20 && (idx < 2 || q16.size() > 0); c++) begin
            @(negedge clk);
            if (idx < 2) begin
                v16 = 1'b1;
                d16 = stim[idx];
                s16 = 6'd0;
            end else begin
                v16 = 1'b0;
            end
            #1;
            if (ov16 && ordy16) begin
                checks++;
                if (q16.size() == 0) begin
                    failures++;
                    $display("FAIL rne_extra got=%h required no beat", o16);
                end else begin
                    expv = q16.pop_front();
                    if (o16 !== expv) begin
                        failures++;
                        $display("FAIL rne_data got=%h required=%h", o16, expv);
                    end
                end
            end
            if (v16 && r16) begin
                q16.push_back(expc[idx]);
                idx++;
            end
        end
        checks++;
        if (idx != 2 || q16.size() != 0) begin
            failures++;
            $display("FAIL rne_timeout sent=%0d pending=%0d required 2/0", idx, q16.size());
        end
    endtask

    task automatic test_saturation();
        logic [63:0] stim [4];
        logic [5:0]  scl  [4];
        logic [63:0] expc [4];
        logic [63:0] expv;
        int idx;
        stim = '{64'h0002_0000_FFFF_0001, 64'h0002_0000_FFFF_0001,
                 64'h0001_0000_8000_0000, 64'h0000_0002_FFFF_0001};
        scl  = '{6'd16, 6'h31, 6'd31, 6'd15};
        expc = '{64'h7C00_0000_FC00_7C00, 64'h0400_0000_8000_0000,
                 64'h7C00_0000_FC00_0000, 64'h0000_7C00_F800_7800};
        idx  = 0;
        ordy16 = 1'b1;
        for (int c = 0; c < 30 && (idx < 4 || q16.size() > 0); c++) begin
            @(negedge clk);
            if (idx < 4) begin
                v16 = 1'b1;
                d16 = stim[idx];
                s16 = scl[idx];
            end else begin
                v16 = 1'b0;
            end
            #1;
            if (ov16 && ordy16) begin
                checks++;
                if (q16.size() == 0) begin
                    failures++;
                    $display("FAIL sat_extra got=%h required no beat", o16);
                end else begin
                    expv = q16.pop_front();
                    if (o16 !== expv) begin
                        failures++;
                        $display("FAIL sat_data got=%h required=%h", o16, expv);
                    end
                end
            end
            if (v16 && r16) begin
                q16.push_back(expc[idx]);
                idx++;
            end
        end
        checks++;
        if (idx != 4 || q16.size() != 0) begin
            failures++;
            $display("FAIL sat_timeout sent=%0d pending=%0d required 4/0", idx, q16.size());
        end
    endtask

    task automatic test_binary();
        logic [1:0]  stim [3];
        logic [5:0]  scl  [3];
        logic [31:0] expc [3];
        logic [31:0] expv;
        int idx;
        stim = '{2'b01, 2'b10, 2'b11};
        scl  = '{6'd0, 6'd1, 6'h20};
        expc = '{32'hBF80_3F80, 32'h4000_C000, 32'h2F80_2F80};
        idx  = 0;
        ordy1 = 1'b1;
        for (int c = 0; c < 20 && (idx < 3 || q1.size() > 0); c++) begin
            @(negedge clk);
            if (idx < 3) begin
                v1 = 1'b1;
                d1 = stim[idx];
                s1 = scl[idx];
            end else begin
                v1 = 1'b0;
            end
            #1;
            if (ov1 && ordy1) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL binary_extra got=%h required no beat", o1);
                end else begin
                    expv = q1.pop_front();
                    if (o1 !== expv) begin
                        failures++;
                        $display("FAIL binary_data got=%h required=%h", o1, expv);
                    end
                end
            end
            if (v1 && r1) begin
                q1.push_back(expc[idx]);
                idx++;
            end
        end
        checks++;
        if (idx != 3 || q1.size() != 0) begin
            failures++;
            $display("FAIL binary_timeout sent=%0d pending=%0d required 3/0", idx, q1.size());
        end
    endtask

    task automatic test_random();
        int          accepted, cycles;
        logic        exp_rdy, prev_stall;
        logic [63:0] prev_data, expv, stim;
        logic [5:0]  sc;
        accepted   = 0;
        cycles     = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (accepted < 10000 && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            ordy16 = ($urandom_range(0, 3) != 0);
            v16    = ($urandom_range(0, 3) != 0);
            stim   = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) sc = 6'($urandom_range(0, 63));
            else sc = 6'(int'($urandom_range(0, 12)) - 6);
            d16 = stim;
            s16 = sc;
            #1;
            exp_rdy = !(q16.size() == 2 && !ordy16);
            checks++;
            if (r16 !== exp_rdy) begin
                failures++;
                $display("FAIL random_ready cycle=%0d got=%b required=%b", cycles, r16, exp_rdy);
            end
            if (prev_stall) begin
                checks++;
                if (ov16 !== 1'b1 || o16 !== prev_data) begin
                    failures++;
                    $display("FAIL random_stall_hold cycle=%0d valid=%b data=%h required 1/%h",
                             cycles, ov16, o16, prev_data);
                end
            end
            if (ov16 && ordy16) begin
                checks++;
                if (q16.size() == 0) begin
                    failures++;
                    $display("FAIL random_extra cycle=%0d got=%h required no beat", cycles, o16);
                end else begin
                    expv = q16.pop_front();
                    if (o16 !== expv) begin
                        failures++;
                        $display("FAIL random_data cycle=%0d got=%h required=%h", cycles, o16, expv);
                    end
                end
            end
            if (v16 && r16) begin
                q16.push_back(exp16(stim, sc));
                accepted++;
            end
            prev_stall = ov16 && !ordy16;
            prev_data  = o16;
        end
        checks++;
        if (accepted < 10000) begin
            failures++;
            $display("FAIL random_timeout accepted=%0d required=10000", accepted);
        end
        @(negedge clk);
        v16    = 1'b0;
        ordy16 = 1'b1;
        for (int c = 0; c < 8 && q16.size() > 0; c++) begin
            #1;
            if (ov16) begin
                expv = q16.pop_front();
                checks++;
                if (o16 !== expv) begin
                    failures++;
                    $display("FAIL random_drain_data got=%h required=%h", o16, expv);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (q16.size() != 0) begin
            failures++;
            $display("FAIL random_drain pending=%0d required=0", q16.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic [63:0] expv;
        @(negedge clk);
        ordy16 = 1'b0;
        v16    = 1'b1;
        d16    = 64'h0000_0000_0000_0011;
        s16    = 6'd0;
        @(negedge clk);
        d16    = 64'h0000_0000_0000_0022;
        @(negedge clk);
        v16    = 1'b0;
        #1;
        checks++;
        if (ov16 !== 1'b1 || r16 !== 1'b0) begin
            failures++;
            $display("FAIL midreset_full valid=%b ready=%b required 1/0", ov16, r16);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ov16, r16, o16} !== {1'b0, 1'b1, 64'h0}) begin
            failures++;
            $display("FAIL midreset_clear valid=%b ready=%b data=%h required 0/1/0", ov16, r16, o16);
        end
        q16.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        ordy16 = 1'b1;
        @(negedge clk);
        v16 = 1'b1;
        d16 = 64'h0007_0000_FFFF_0001;
        s16 = 6'd0;
        q16.push_back(64'h4700_0000_BC00_3C00);
        @(posedge clk);
        #1;
        v16 = 1'b0;
        checks++;
        if (ov16 !== 1'b0) begin
            failures++;
            $display("FAIL midreset_latency_early valid=%b required=0", ov16);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ov16 !== 1'b1) begin
            failures++;
            $display("FAIL midreset_latency valid=%b required=1", ov16);
        end
        expv = q16.pop_front();
        checks++;
        if (o16 !== expv) begin
            failures++;
            $display("FAIL midreset_data got=%h required=%h", o16, expv);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        v4  = 1'b0; ordy4  = 1'b1; d4  = '0; s4  = '0;
        v16 = 1'b0; ordy16 = 1'b1; d16 = '0; s16 = '0;
        v1  = 1'b0; ordy1  = 1'b1; d1  = '0; s1  = '0;
        test_reset();
        test_int4_basic();
        test_rne();
        test_saturation();
        test_binary();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
